// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port between N_REQ pixel engines,
// with a registered output stage, active-area range check and a raster-order clear sequencer.
module fb_write_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned RGB_W    = 8,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ*(X_W+Y_W+RGB_W)-1:0]   req_data,
    input  logic                               clear_start,
    input  logic [RGB_W-1:0]                   clear_rgb,
    output logic                               clear_busy,
    output logic                               fb_write,
    input  logic                               fb_wr_ready,
    output logic [X_W-1:0]                     fb_pix_x,
    output logic [Y_W-1:0]                     fb_pix_y,
    output logic [RGB_W-1:0]                   fb_wrgb,
    output logic [31:0]                        wr_count,
    output logic [15:0]                        drop_count
);

    localparam int unsigned D     = X_W + Y_W + RGB_W;
    localparam int unsigned PTR_W = $clog2(N_REQ);

    localparam logic [X_W-1:0]   X_LIM  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   Y_LIM  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [PTR_W-1:0] RR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {StArb, StDrain, StClear} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [RGB_W-1:0]   clr_rgb_q, clr_rgb_d;
    logic [X_W-1:0]     cx_q, cx_d;
    logic [Y_W-1:0]     cy_q, cy_d;

    logic               fb_write_d;
    logic [X_W-1:0]     fb_pix_x_d;
    logic [Y_W-1:0]     fb_pix_y_d;
    logic [RGB_W-1:0]   fb_wrgb_d;
    logic [31:0]        wr_count_d;
    logic [15:0]        drop_count_d;

    logic               slot_free;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand;
    logic [D-1:0]       sel;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [RGB_W-1:0]   sel_rgb;
    logic               accept;
    logic               load;
    logic               drop;
    logic [X_W-1:0]     load_x;
    logic [Y_W-1:0]     load_y;
    logic [RGB_W-1:0]   load_rgb;

    assign slot_free  = !fb_write || fb_wr_ready;
    assign clear_busy = (state_q != StArb);

    // Rotating priority search starting at rr_q; depends only on req_valid.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign sel     = req_data[grant_idx*D +: D];
    assign sel_x   = sel[D-1 -: X_W];
    assign sel_y   = sel[RGB_W +: Y_W];
    assign sel_rgb = sel[RGB_W-1:0];
    assign accept  = (state_q == StArb) && grant_found && slot_free;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        clr_rgb_d = clr_rgb_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        load      = 1'b0;
        drop      = 1'b0;
        load_x    = sel_x;
        load_y    = sel_y;
        load_rgb  = sel_rgb;
        req_ready = '0;
        case (state_q)
            StArb: begin
                if (accept) begin
                    req_ready[grant_idx] = 1'b1;
                    rr_d = (grant_idx == RR_LAST) ? '0 : grant_idx + PTR_W'(1);
                    if (sel_x < X_LIM && sel_y < Y_LIM) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (clear_start) begin
                    clr_rgb_d = clear_rgb;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (slot_free) begin
                    state_d = StClear;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StClear: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_x   = cx_q;
                    load_y   = cy_q;
                    load_rgb = clr_rgb_q;
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        if (cy_q == Y_LAST) begin
                            state_d = StArb;
                        end else begin
                            cy_d = cy_q + Y_W'(1);
                        end
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                end
            end
            default: state_d = StArb;
        endcase
        // Nothing is offered while reset is held.
        if (!reset_n) begin
            req_ready = '0;
        end
    end

    always_comb begin
        fb_write_d   = fb_write && !fb_wr_ready;
        fb_pix_x_d   = fb_pix_x;
        fb_pix_y_d   = fb_pix_y;
        fb_wrgb_d    = fb_wrgb;
        wr_count_d   = wr_count + 32'((fb_write && fb_wr_ready) ? 1 : 0);
        drop_count_d = drop_count;
        if (load) begin
            fb_write_d = 1'b1;
            fb_pix_x_d = load_x;
            fb_pix_y_d = load_y;
            fb_wrgb_d  = load_rgb;
        end
        if (drop && drop_count != 16'hFFFF) begin
            drop_count_d = drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StArb;
            rr_q       <= '0;
            clr_rgb_q  <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            fb_write   <= 1'b0;
            fb_pix_x   <= '0;
            fb_pix_y   <= '0;
            fb_wrgb    <= '0;
            wr_count   <= '0;
            drop_count <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            clr_rgb_q  <= clr_rgb_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            fb_write   <= fb_write_d;
            fb_pix_x   <= fb_pix_x_d;
            fb_pix_y   <= fb_pix_y_d;
            fb_wrgb    <= fb_wrgb_d;
            wr_count   <= wr_count_d;
            drop_count <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a 640x480 instance for arbitration/range tests and a
// 4x3 instance (same stimulus) for the clear sequencer.
module tb_fb_write_arbiter;

    localparam int N = 4;
    localparam int D = 28;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*D-1:0] req_data;
    logic           clear_start;
    logic [7:0]     clear_rgb;
    logic           fb_wr_ready;

    logic [N-1:0]   req_ready, s_req_ready;
    logic           clear_busy, s_clear_busy;
    logic           fb_write, s_fb_write;
    logic [9:0]     fb_pix_x, s_fb_pix_x;
    logic [9:0]     fb_pix_y, s_fb_pix_y;
    logic [7:0]     fb_wrgb, s_fb_wrgb;
    logic [31:0]    wr_count, s_wr_count;
    logic [15:0]    drop_count, s_drop_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fb_write_arbiter u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .clear_start(clear_start), .clear_rgb(clear_rgb),
        .clear_busy(clear_busy), .fb_write(fb_write), .fb_wr_ready(fb_wr_ready),
        .fb_pix_x(fb_pix_x), .fb_pix_y(fb_pix_y), .fb_wrgb(fb_wrgb),
        .wr_count(wr_count), .drop_count(drop_count)
    );

    fb_write_arbiter #(.H_ACTIVE(4), .V_ACTIVE(3)) u_small (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_data(req_data), .clear_start(clear_start), .clear_rgb(clear_rgb),
        .clear_busy(s_clear_busy), .fb_write(s_fb_write), .fb_wr_ready(fb_wr_ready),
        .fb_pix_x(s_fb_pix_x), .fb_pix_y(s_fb_pix_y), .fb_wrgb(s_fb_wrgb),
        .wr_count(s_wr_count), .drop_count(s_drop_count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] rgb);
        req_data[i*D +: D] = {x, y, rgb};
    endtask

    task automatic apply_reset();
        req_valid   = '0;
        req_data    = '0;
        clear_start = 1'b0;
        clear_rgb   = '0;
        fb_wr_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid   = 4'b1111;
        req_data    = '0;
        clear_start = 1'b0;
        clear_rgb   = '0;
        fb_wr_ready = 1'b1;
        reset_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (fb_write !== 1'b0 || fb_pix_x !== 10'd0 || fb_pix_y !== 10'd0 ||
                        fb_wrgb !== 8'd0) begin n_fail++;
            $display("FAIL reset_fb: got w=%b x=%0d y=%0d rgb=%h expected all 0",
                     fb_write, fb_pix_x, fb_pix_y, fb_wrgb); end
        n_checks++; if (clear_busy !== 1'b0 || wr_count !== 32'd0 || drop_count !== 16'd0)
        begin n_fail++;
            $display("FAIL reset_status: got busy=%b wr=%0d drop=%0d expected 0 0 0",
                     clear_busy, wr_count, drop_count); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        set_req(1, 10'd5, 10'd7, 8'hE0);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL single_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (fb_write !== 1'b1 || fb_pix_x !== 10'd5 || fb_pix_y !== 10'd7 ||
                        fb_wrgb !== 8'hE0) begin n_fail++;
            $display("FAIL single_out: got w=%b x=%0d y=%0d rgb=%h expected 1 5 7 e0",
                     fb_write, fb_pix_x, fb_pix_y, fb_wrgb); end
        @(negedge clk);
        n_checks++; if (wr_count !== 32'd1 || fb_write !== 1'b0) begin n_fail++;
            $display("FAIL single_commit: got wr=%0d w=%b expected 1 0", wr_count, fb_write); end
    endtask

    task automatic test_contention();
        int ord[10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
        logic [3:0] exp_rdy;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 10'(100 + i), 10'(i), 8'(i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'b1111;
            if (c == 6) req_valid = 4'b1011;
            #1;
            exp_rdy = 4'b0001 << ord[c];
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++;
                $display("FAIL rr_order[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
            if (c > 0) begin
                n_checks++; if (fb_write !== 1'b1 || fb_pix_x !== 10'(100 + ord[c-1])) begin
                    n_fail++;
                    $display("FAIL rr_data[%0d]: got w=%b x=%0d expected 1 %0d", c, fb_write,
                             fb_pix_x, 100 + ord[c-1]); end
            end
        end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (fb_pix_x !== 10'd103 || wr_count !== 32'd9) begin n_fail++;
            $display("FAIL rr_tail: got x=%0d wr=%0d expected 103 9", fb_pix_x, wr_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        set_req(0, 10'd10, 10'd20, 8'hAA);
        req_valid = 4'b0001;
        @(negedge clk);
        fb_wr_ready = 1'b0;
        set_req(1, 10'd11, 10'd21, 8'hBB);
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000 || fb_write !== 1'b1 ||
                            fb_pix_x !== 10'd10 || fb_pix_y !== 10'd20 || fb_wrgb !== 8'hAA ||
                            wr_count !== 32'd0) begin n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b w=%b x=%0d y=%0d rgb=%h wr=%0d expected 0000 1 10 20 aa 0",
                         c, req_ready, fb_write, fb_pix_x, fb_pix_y, fb_wrgb, wr_count); end
            @(negedge clk);
        end
        fb_wr_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (fb_write !== 1'b1 || fb_pix_x !== 10'd11 || fb_wrgb !== 8'hBB ||
                        wr_count !== 32'd1) begin n_fail++;
            $display("FAIL bp_release: got w=%b x=%0d rgb=%h wr=%0d expected 1 11 bb 1",
                     fb_write, fb_pix_x, fb_wrgb, wr_count); end
    endtask

    task automatic test_range();
        apply_reset();
        @(negedge clk);
        set_req(0, 10'd640, 10'd0, 8'h11);
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL range_accept_x: got %b expected 0001", req_ready); end
        @(negedge clk);
        set_req(0, 10'd0, 10'd480, 8'h22);
        #1;
        n_checks++; if (req_ready !== 4'b0001 || fb_write !== 1'b0 || drop_count !== 16'd1)
        begin n_fail++;
            $display("FAIL range_drop_x: got rdy=%b w=%b drop=%0d expected 0001 0 1",
                     req_ready, fb_write, drop_count); end
        @(negedge clk);
        set_req(0, 10'd639, 10'd479, 8'h33);
        #1;
        n_checks++; if (fb_write !== 1'b0 || drop_count !== 16'd2) begin n_fail++;
            $display("FAIL range_drop_y: got w=%b drop=%0d expected 0 2", fb_write, drop_count); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (fb_write !== 1'b1 || fb_pix_x !== 10'd639 || fb_pix_y !== 10'd479 ||
                        fb_wrgb !== 8'h33 || drop_count !== 16'd2) begin n_fail++;
            $display("FAIL range_edge: got w=%b x=%0d y=%0d rgb=%h drop=%0d expected 1 639 479 33 2",
                     fb_write, fb_pix_x, fb_pix_y, fb_wrgb, drop_count); end
    endtask

    task automatic test_clear();
        int  idx = 0;
        logic done = 1'b0;
        apply_reset();
        @(negedge clk);
        set_req(0, 10'd1, 10'd1, 8'h55);
        req_valid   = 4'b0001;
        clear_start = 1'b1;
        clear_rgb   = 8'h1C;
        #1;
        n_checks++; if (s_req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL clr_same_cycle_accept: got %b expected 0001", s_req_ready); end
        @(negedge clk);
        clear_start = 1'b0;
        clear_rgb   = 8'hFF;
        n_checks++; if (s_clear_busy !== 1'b1 || s_req_ready !== 4'b0000 || s_fb_write !== 1'b1 ||
                        s_fb_pix_x !== 10'd1 || s_fb_wrgb !== 8'h55) begin n_fail++;
            $display("FAIL clr_enter: got busy=%b rdy=%b w=%b x=%0d rgb=%h expected 1 0000 1 1 55",
                     s_clear_busy, s_req_ready, s_fb_write, s_fb_pix_x, s_fb_wrgb); end
        for (int it = 0; it < 40 && !done; it++) begin
            @(negedge clk);
            clear_start = (it == 3);
            if (s_fb_write) begin
                n_checks++; if (s_fb_pix_x !== 10'(idx % 4) || s_fb_pix_y !== 10'(idx / 4) ||
                                s_fb_wrgb !== 8'h1C) begin n_fail++;
                    $display("FAIL clr_pixel[%0d]: got x=%0d y=%0d rgb=%h expected %0d %0d 1c",
                             idx, s_fb_pix_x, s_fb_pix_y, s_fb_wrgb, idx % 4, idx / 4); end
                idx++;
            end
            if (s_clear_busy) begin
                n_checks++; if (s_req_ready !== 4'b0000) begin n_fail++;
                    $display("FAIL clr_ready_blocked[%0d]: got %b expected 0000", it,
                             s_req_ready); end
            end else begin
                done = 1'b1;
            end
        end
        clear_start = 1'b0;
        n_checks++; if (!done || idx !== 12) begin n_fail++;
            $display("FAIL clr_count: got done=%b writes=%0d expected 1 12", done, idx); end
        n_checks++; if (s_req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL clr_resume_ready: got %b expected 0001", s_req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (s_fb_write !== 1'b1 || s_fb_pix_x !== 10'd1 || s_fb_pix_y !== 10'd1 ||
                        s_fb_wrgb !== 8'h55 || s_wr_count !== 32'd13) begin n_fail++;
            $display("FAIL clr_resume: got w=%b x=%0d y=%0d rgb=%h wr=%0d expected 1 1 1 55 13",
                     s_fb_write, s_fb_pix_x, s_fb_pix_y, s_fb_wrgb, s_wr_count); end
    endtask

    task automatic test_reset_mid_clear();
        int seen = 0;
        apply_reset();
        @(negedge clk);
        clear_start = 1'b1;
        clear_rgb   = 8'h1C;
        @(negedge clk);
        clear_start = 1'b0;
        for (int it = 0; it < 40 && seen < 5; it++) begin
            @(negedge clk);
            if (s_fb_write) seen++;
        end
        n_checks++; if (seen !== 5 || s_clear_busy !== 1'b1 || s_wr_count !== 32'd4) begin
            n_fail++;
            $display("FAIL mid_clear_progress: got seen=%0d busy=%b wr=%0d expected 5 1 4",
                     seen, s_clear_busy, s_wr_count); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (s_fb_write !== 1'b0 || s_clear_busy !== 1'b0 || s_wr_count !== 32'd0 ||
                        s_drop_count !== 16'd0 || s_fb_pix_x !== 10'd0 ||
                        s_req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL mid_clear_reset: got w=%b busy=%b wr=%0d drop=%0d x=%0d rdy=%b expected all 0",
                     s_fb_write, s_clear_busy, s_wr_count, s_drop_count, s_fb_pix_x,
                     s_req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        set_req(2, 10'd2, 10'd1, 8'h77);
        req_valid = 4'b0100;
        #1;
        n_checks++; if (s_req_ready !== 4'b0100) begin n_fail++;
            $display("FAIL post_reset_ready: got %b expected 0100", s_req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (s_fb_write !== 1'b1 || s_fb_pix_x !== 10'd2 || s_fb_pix_y !== 10'd1 ||
                        s_fb_wrgb !== 8'h77 || s_clear_busy !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_write: got w=%b x=%0d y=%0d rgb=%h busy=%b expected 1 2 1 77 0",
                     s_fb_write, s_fb_pix_x, s_fb_pix_y, s_fb_wrgb, s_clear_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_range();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single HPS-side framebuffer write port between N_REQ Mandelbrot pixel engines.
- Round-robin arbitration, one registered output stage with backpressure, and range checking against the active area.
- Built-in clear sequencer fills the whole framebuffer with one colour in raster order.
- Sits between the compute engines and the framebuffer write port (pix_x/pix_y/wrgb/write), in the system clock domain.

Parameters:
N_REQ, 4, number of requesting engines (2..8)
X_W, 10, pixel x width
Y_W, 10, pixel y width
RGB_W, 8, pixel colour width (RGB332)
H_ACTIVE, 640, active pixels per line; valid x is 0..H_ACTIVE-1
V_ACTIVE, 480, active lines; valid y is 0..V_ACTIVE-1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-engine write request
req_ready  out  N_REQ  per-engine accept; transfer when valid&&ready
req_data  in  N_REQ*(X_W+Y_W+RGB_W)  flattened; slice i = {x,y,rgb} at [(i+1)*D-1 : i*D]
clear_start  in  1  one-cycle pulse; begin framebuffer fill
clear_rgb  in  RGB_W  fill colour, sampled on clear_start
clear_busy  out  1  high while clear pending or running
fb_write  out  1  write strobe to framebuffer
fb_wr_ready  in  1  framebuffer accepts this cycle; commit = fb_write&&fb_wr_ready
fb_pix_x  out  X_W  write x
fb_pix_y  out  Y_W  write y
fb_wrgb  out  RGB_W  write colour
wr_count  out  32  committed writes, wraps at 2^32
drop_count  out  16  out-of-range requests discarded, saturates at 16'hFFFF

Behaviour:
- Reset (async, reset_n=0): state=ARB; rr pointer=0; fb_write=0; fb_pix_x/y/wrgb=0; clear_busy=0; wr_count=0; drop_count=0; req_ready=0 (combinational, follows state).
- Output stage: registers fb_write, fb_pix_x, fb_pix_y, fb_wrgb. slot_free = !fb_write || fb_wr_ready. When slot_free and nothing is loaded, fb_write drops to 0 next cycle. While fb_write=1 && fb_wr_ready=0, all outputs are held stable.
- ARB state:
  - Winner = first i with req_valid[i]=1, searching from rr pointer upward with wrap.
  - req_ready[winner] = slot_free; all others 0. req_ready has no combinational dependence on req_data.
  - On accept: if x<H_ACTIVE and y<V_ACTIVE, load the output stage next cycle (latency 1: accept at cycle n, fb_write=1 at n+1). Otherwise load nothing and increment drop_count.
  - Either way, rr pointer = winner+1 mod N_REQ.
  - Throughput: one accept per cycle with fb_wr_ready held 1.
- clear_start handling:
  - In ARB: latch clear_rgb, set clear_busy=1, force req_ready=0 from the next cycle, go to DRAIN. A same-cycle req accept still completes.
  - In DRAIN or CLEAR: ignored; the colour is not re-latched.
- DRAIN: wait until slot_free, then go to CLEAR with counters cx=0, cy=0.
- CLEAR:
  - Each cycle slot_free: load {cx,cy,latched rgb}; cx++. When cx=H_ACTIVE-1: cx=0, cy++.
  - After loading (H_ACTIVE-1, V_ACTIVE-1), go to ARB. clear_busy falls in the same cycle, the output stage still holds the last pixel.
  - Exactly H_ACTIVE*V_ACTIVE writes, raster order. req_ready=0 throughout. rr pointer is unchanged.
- wr_count increments on every commit, including clear writes. drop_count counts only requester drops.
- Reset asserted mid-operation aborts immediately to reset values. A partial clear is not resumed.
- The block does no coordinate arithmetic beyond the compares and counters. Comparisons are unsigned at X_W/Y_W widths.

Test Plan:
- Single requester: req 1 valid {x=5,y=7,rgb=8'hE0}, fb_wr_ready=1 -> req_ready[1]=1 same cycle; next cycle fb_write=1, x=5, y=7, wrgb=E0; wr_count=1.
- Contention: all 4 valid continuously, fb_wr_ready=1 -> accept order 0,1,2,3,0,1 one per cycle; then drop req 2 -> order skips 2.
- Backpressure: fb_wr_ready=0 for 5 cycles with fb_write=1 -> fb_* outputs stable, all req_ready=0, wr_count unchanged; on release the held write commits and the next request is accepted the same cycle.
- Range: req {x=640,y=0} then {x=0,y=480} -> both accepted, no fb_write, drop_count=2; {x=639,y=479} -> written.
- Clear with H_ACTIVE=4, V_ACTIVE=3, clear_rgb=8'h1C while a requester is valid -> exactly 12 writes (0,0)..(3,2) in raster order, all wrgb=1C; req_ready=0 until clear_busy falls, then arbitration resumes; second clear_start mid-fill ignored.
- Reset mid-clear: reset_n=0 after 5 clear writes -> fb_write=0, clear_busy=0, counts 0 immediately (async); after release, state ARB and a new request is serviced normally.
